// File: rtl/udcounter_vote.sv
// N-channel saturating up/down counter bank with a registered majority-vote
// hard decision, warm-up valid, decision-change strobe and saturation flags.
module udcounter_vote #(
    parameter int NCH    = 3,
    parameter int CSIZE  = 4,
    parameter int PSAT   = 7,
    parameter int NSAT   = 7,
    parameter int WARMUP = 16
) (
    input  logic                       CLK,
    input  logic                       INIT,
    input  logic                       EN,
    input  logic                       CLR,
    input  logic [NCH-1:0]             BitIN,
    output logic                       BitOUT,
    output logic                       VALID,
    output logic                       CHANGED,
    output logic [$clog2(NCH+1)-1:0]   VOTE_CNT,
    output logic [NCH-1:0]             SAT
);

    localparam int VW = $clog2(NCH+1);
    localparam int WW = $clog2(WARMUP+1);
    localparam logic [CSIZE-1:0] C_PMAX = CSIZE'(PSAT);
    localparam logic [CSIZE-1:0] C_NMIN = CSIZE'(-NSAT);

    logic [NCH-1:0][CSIZE-1:0] r_cnt;
    logic [NCH-1:0][CSIZE-1:0] w_cnt_nxt;
    logic [NCH-1:0]            w_sat_nxt;
    logic [VW-1:0]             w_neg;
    logic                      w_bit_nxt;
    logic [WW-1:0]             r_warm;
    logic [WW-1:0]             w_warm_nxt;
    logic                      r_bit;
    logic                      r_valid;
    logic                      r_changed;
    logic [VW-1:0]             r_vote;
    logic [NCH-1:0]            r_sat;

    // Vote and flags are taken from the next-state counters so a sample shows
    // up on the outputs right after the edge that consumes it.
    always_comb begin
        w_neg     = '0;
        w_sat_nxt = '0;
        w_cnt_nxt = r_cnt;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (BitIN[c] && (r_cnt[c] != C_PMAX))
                w_cnt_nxt[c] = r_cnt[c] + CSIZE'(1);
            else if (!BitIN[c] && (r_cnt[c] != C_NMIN))
                w_cnt_nxt[c] = r_cnt[c] - CSIZE'(1);
            w_neg        = w_neg + VW'(w_cnt_nxt[c][CSIZE-1]);
            w_sat_nxt[c] = (w_cnt_nxt[c] == C_PMAX) || (w_cnt_nxt[c] == C_NMIN);
        end
        w_bit_nxt  = !(w_neg > VW'(NCH/2));
        w_warm_nxt = (r_warm == WW'(WARMUP)) ? r_warm : r_warm + WW'(1);
    end

    always_ff @(posedge CLK or posedge INIT) begin
        if (INIT) begin
            r_cnt     <= '0;
            r_bit     <= 1'b1;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_vote    <= '0;
            r_sat     <= '0;
            r_warm    <= '0;
        end else if (CLR) begin
            r_cnt     <= '0;
            r_bit     <= 1'b1;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_vote    <= '0;
            r_sat     <= '0;
            r_warm    <= '0;
        end else if (EN) begin
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_vote    <= w_neg;
            r_sat     <= w_sat_nxt;
            r_warm    <= w_warm_nxt;
            r_valid   <= (w_warm_nxt == WW'(WARMUP));
            r_changed <= r_valid && (w_bit_nxt != r_bit);
        end else begin
            r_changed <= 1'b0;
        end
    end

    assign BitOUT   = r_bit;
    assign VALID    = r_valid;
    assign CHANGED  = r_changed;
    assign VOTE_CNT = r_vote;
    assign SAT      = r_sat;

endmodule
